// File: rtl/adapter_axi_stream_2_bram_if.sv
// Signal bundle between an AXI Stream source / BRAM write port and the
// stream-to-BRAM adapter. The slave modport is the adapter's view; the
// master modport is the view of whatever drives the stream and grants buffers.
interface adapter_axi_stream_2_bram_if #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int BRAM_DEPTH      = 8,
    parameter int USER_DEPTH      = 1
);
    // AXI Stream side
    logic [USER_DEPTH-1:0]      i_axis_user;
    logic                       i_axis_valid;
    logic                       o_axis_ready;
    logic [AXIS_DATA_WIDTH-1:0] i_axis_data;
    logic                       i_axis_last;

    // Buffer grant and BRAM write side
    logic                       i_bram_en;
    logic [BRAM_DEPTH-1:0]      i_bram_size;
    logic                       o_bram_we;
    logic [BRAM_DEPTH-1:0]      o_bram_addr;
    logic [AXIS_DATA_WIDTH-1:0] o_bram_data;
    logic [USER_DEPTH-1:0]      o_bram_user;
    logic [BRAM_DEPTH-1:0]      o_bram_count;
    logic                       o_bram_fin;
    logic                       o_bram_last;

    modport slave (
        input  i_axis_user, i_axis_valid, i_axis_data, i_axis_last,
        input  i_bram_en, i_bram_size,
        output o_axis_ready,
        output o_bram_we, o_bram_addr, o_bram_data, o_bram_user,
        output o_bram_count, o_bram_fin, o_bram_last
    );

    modport master (
        output i_axis_user, i_axis_valid, i_axis_data, i_axis_last,
        output i_bram_en, i_bram_size,
        input  o_axis_ready,
        input  o_bram_we, o_bram_addr, o_bram_data, o_bram_user,
        input  o_bram_count, o_bram_fin, o_bram_last
    );
endinterface

// File: rtl/adapter_axi_stream_2_bram.sv
// AXI Stream to BRAM adapter. Each granted buffer is filled from address 0
// upward, one word per accepted beat, until the packet ends (i_axis_last) or
// the buffer reaches its granted size. The buffer is then handed back with
// o_bram_fin, the word count, the user sideband of its first beat and a flag
// telling whether it ended on a packet boundary. A packet that overflows a
// buffer simply continues into the next grant.
module adapter_axi_stream_2_bram #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int BRAM_DEPTH      = 8,
    parameter int USER_DEPTH      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    adapter_axi_stream_2_bram_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Capacity of the current buffer, captured at grant time.
    logic [BRAM_DEPTH-1:0]      size_r;

    // Stream handshake.
    logic                       ready_r;
    logic                       accept;

    // Registered BRAM write port (one stage behind the accepted beat).
    logic                       we_p1;
    logic [BRAM_DEPTH-1:0]      addr_p1;
    logic [AXIS_DATA_WIDTH-1:0] data_p1;

    // Per-buffer status reported back to the buffer owner.
    logic [BRAM_DEPTH-1:0]      count_r;
    logic [USER_DEPTH-1:0]      user_r;
    logic                       last_r;
    logic                       fin_r;

    // Fill detection is one bit wider than the count so a full-size buffer
    // (2^BRAM_DEPTH-1 words) never wraps the comparison.
    logic [BRAM_DEPTH:0]        count_inc;
    logic                       fill_hit;

    assign accept    = (state == WRITE) && bus.i_axis_valid && ready_r;
    assign count_inc = {1'b0, count_r} + {{BRAM_DEPTH{1'b0}}, 1'b1};
    assign fill_hit  = (count_inc == {1'b0, size_r});

    // Next-state logic; a withdrawn grant always wins and returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.i_bram_en) begin
                    next_state = (bus.i_bram_size == '0) ? FIN : WRITE;
                end
            end
            WRITE: begin
                if (!bus.i_bram_en) begin
                    next_state = IDLE;
                end else if (accept && (bus.i_axis_last || fill_hit)) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                next_state = bus.i_bram_en ? FIN : IDLE;
            end
            FIN: begin
                if (!bus.i_bram_en) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the granted buffer capacity when IDLE first sees the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_r <= '0;
        end else if ((state == IDLE) && bus.i_bram_en) begin
            size_r <= bus.i_bram_size;
        end
    end

    // Ready is registered: high for every WRITE cycle that stays in WRITE,
    // so it drops on the same edge that accepts the closing beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= (state == WRITE) && (next_state == WRITE);
        end
    end

    // BRAM write port: each accepted beat is presented for exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_p1   <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            we_p1 <= accept;
            if (accept) begin
                addr_p1 <= count_r;
                data_p1 <= bus.i_axis_data;
            end
        end
    end

    // Buffer status: cleared in IDLE, updated per beat in WRITE, held in FIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
            user_r  <= '0;
            last_r  <= 1'b0;
        end else if (state == IDLE) begin
            count_r <= '0;
            last_r  <= 1'b0;
        end else if (accept) begin
            count_r <= count_inc[BRAM_DEPTH-1:0];
            last_r  <= bus.i_axis_last;
            if (count_r == '0) begin
                user_r <= bus.i_axis_user;
            end
        end
    end

    // Completion flag follows FIN one cycle late, so the final write has
    // already landed and the flag clears one cycle after the grant drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_r <= 1'b0;
        end else begin
            fin_r <= (state == FIN);
        end
    end

    assign bus.o_axis_ready = ready_r;
    assign bus.o_bram_we    = we_p1;
    assign bus.o_bram_addr  = addr_p1;
    assign bus.o_bram_data  = data_p1;
    assign bus.o_bram_user  = user_r;
    assign bus.o_bram_count = count_r;
    assign bus.o_bram_fin   = fin_r;
    assign bus.o_bram_last  = last_r;

endmodule

// File: tb/tb_adapter_axi_stream_2_bram.sv
// Bench for adapter_axi_stream_2_bram: a stream of packets is offered with
// random valid gaps, buffers are granted with chosen sizes, and every buffer
// is compared with what the packet/size rules say it must contain.
module tb_adapter_axi_stream_2_bram;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int UW = 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    adapter_axi_stream_2_bram_if #(
        .AXIS_DATA_WIDTH(DW), .BRAM_DEPTH(AW), .USER_DEPTH(UW)
    ) bus ();

    adapter_axi_stream_2_bram #(
        .AXIS_DATA_WIDTH(DW), .BRAM_DEPTH(AW), .USER_DEPTH(UW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int n_err    = 0;
    int n_checks = 0;

    beat_t         src_q[$];
    logic [DW-1:0] mem [256];
    int            wr_addr_q[$];

    // BRAM model: captures the registered write port on each rising edge.
    always @(posedge clk) begin
        if (bus.o_bram_we === 1'b1) begin
            mem[bus.o_bram_addr] <= bus.o_bram_data;
            wr_addr_q.push_back(int'(bus.o_bram_addr));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"}, 64'(bus.o_axis_ready), 0);
        check({tag, " we"},    64'(bus.o_bram_we),    0);
        check({tag, " fin"},   64'(bus.o_bram_fin),   0);
        check({tag, " last"},  64'(bus.o_bram_last),  0);
        check({tag, " addr"},  64'(bus.o_bram_addr),  0);
        check({tag, " data"},  64'(bus.o_bram_data),  0);
        check({tag, " user"},  64'(bus.o_bram_user),  0);
        check({tag, " count"}, 64'(bus.o_bram_count), 0);
    endtask

    task automatic push_packet(input int n, input logic [UW-1:0] first_user);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = $urandom;
            b.user = (i == 0) ? first_user : UW'(0);
            b.last = (i == n - 1);
            src_q.push_back(b);
        end
    endtask

    // Drive one cycle of stream from a negedge to the next negedge.
    task automatic step_stream(input int vpct, output bit accepted);
        if (src_q.size() > 0 && int'($urandom_range(99)) < vpct) begin
            bus.i_axis_valid = 1'b1;
            bus.i_axis_data  = src_q[0].data;
            bus.i_axis_user  = src_q[0].user;
            bus.i_axis_last  = src_q[0].last;
        end else begin
            bus.i_axis_valid = 1'b0;
            bus.i_axis_data  = $urandom;
            bus.i_axis_user  = UW'($urandom);
            bus.i_axis_last  = 1'($urandom);
        end
        accepted = bus.i_axis_valid && bus.o_axis_ready;
        @(posedge clk);
        if (accepted) void'(src_q.pop_front());
        @(negedge clk);
    endtask

    // Grant one buffer, stream into it, check it against the packet rules,
    // then release it. Starts and ends at a negedge.
    task automatic do_buffer(input int size, input int vpct, input string tag);
        int            n_exp;
        bit            last_exp;
        logic [UW-1:0] user_exp;
        logic [DW-1:0] exp_data[$];
        int            acc, cyc, k_last, fin_cyc, first_rdy, bad_addr, bad_data;
        bit            fin_seen, late_ready, accepted;

        // Expected buffer: beats up to the first last, capped at size.
        n_exp = 0; last_exp = 0; user_exp = '0;
        if (src_q.size() > 0) user_exp = src_q[0].user;
        foreach (src_q[i]) begin
            if (n_exp >= size) break;
            exp_data.push_back(src_q[i].data);
            n_exp++;
            if (src_q[i].last) begin
                last_exp = 1'b1;
                break;
            end
        end

        wr_addr_q.delete();
        bus.i_bram_en   = 1'b1;
        bus.i_bram_size = AW'(size);
        @(posedge clk);
        @(negedge clk);

        acc = 0; cyc = 0; k_last = -1; fin_cyc = -1; first_rdy = -1;
        fin_seen = 0; late_ready = 0;
        while (cyc < 1000) begin
            if (cyc == 0) bus.i_bram_size = AW'($urandom);
            if (bus.o_bram_fin === 1'b1) begin
                fin_seen = 1;
                fin_cyc  = cyc;
                break;
            end
            if (bus.o_axis_ready === 1'b1 && first_rdy < 0) first_rdy = cyc;
            if (bus.o_axis_ready === 1'b1 && acc >= n_exp) late_ready = 1;
            step_stream(vpct, accepted);
            cyc++;
            if (accepted) begin
                acc++;
                if (acc == n_exp) k_last = cyc;
            end
        end
        bus.i_axis_valid = 1'b0;

        check({tag, " fin_seen"},    64'(fin_seen), 1);
        check({tag, " fin_time"},    64'(fin_cyc), 64'(k_last + 2));
        check({tag, " ready_start"}, 64'(first_rdy), 64'((n_exp > 0) ? 1 : -1));
        check({tag, " ready_late"},  64'(late_ready), 0);
        check({tag, " accepted"},    64'(acc), 64'(n_exp));
        check({tag, " count"},       64'(bus.o_bram_count), 64'(n_exp));
        check({tag, " last"},        64'(bus.o_bram_last), 64'(last_exp));
        if (n_exp > 0) check({tag, " user"}, 64'(bus.o_bram_user), 64'(user_exp));
        check({tag, " writes"},      64'(wr_addr_q.size()), 64'(n_exp));
        bad_addr = 0; bad_data = 0;
        for (int i = 0; i < n_exp; i++) begin
            if (i >= wr_addr_q.size() || wr_addr_q[i] != i) bad_addr++;
            if (mem[i] !== exp_data[i]) bad_data++;
        end
        check({tag, " bad_addr"}, 64'(bad_addr), 0);
        check({tag, " bad_data"}, 64'(bad_data), 0);

        // Status must hold while the grant stays up.
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check({tag, " hold_fin"},   64'(bus.o_bram_fin), 1);
        check({tag, " hold_count"}, 64'(bus.o_bram_count), 64'(n_exp));

        // Release: fin stays for the sampling edge, clears on the next one.
        bus.i_bram_en = 1'b0;
        @(negedge clk);
        check({tag, " rel_fin_f"}, 64'(bus.o_bram_fin), 1);
        @(negedge clk);
        check({tag, " rel_fin"},   64'(bus.o_bram_fin), 0);
        check({tag, " rel_count"}, 64'(bus.o_bram_count), 0);
        check({tag, " rel_last"},  64'(bus.o_bram_last), 0);
    endtask

    initial begin
        beat_t b;
        bit    accepted;
        int    acc;
        bit    fin_any;

        bus.i_axis_valid = 1'b0;
        bus.i_axis_data  = '0;
        bus.i_axis_user  = '0;
        bus.i_axis_last  = 1'b0;
        bus.i_bram_en    = 1'b0;
        bus.i_bram_size  = '0;
        rst = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Short packet 0xA0..0xA2, user set on the first beat only
        for (int i = 0; i < 3; i++) begin
            b.data = 32'hA0 + 32'(i);
            b.user = (i == 0) ? UW'(1) : UW'(0);
            b.last = (i == 2);
            src_q.push_back(b);
        end
        do_buffer(8, 100, "short");

        // Buffer fill, then the rest of the packet in the next grant
        push_packet(6, UW'(1));
        do_buffer(4, 100, "fill_a");
        do_buffer(8, 100, "fill_b");

        // Backpressure gaps
        push_packet(4, UW'(0));
        do_buffer(8, 50, "gaps");

        // Zero size with a packet waiting: nothing may be accepted
        push_packet(3, UW'(1));
        do_buffer(0, 100, "zero");
        do_buffer(8, 100, "after_zero");

        // Grant withdrawn after two beats
        push_packet(6, UW'(0));
        wr_addr_q.delete();
        bus.i_bram_en   = 1'b1;
        bus.i_bram_size = AW'(8);
        acc = 0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            step_stream(100, accepted);
            if (accepted) acc++;
        end
        bus.i_axis_valid = 1'b0;
        bus.i_bram_en    = 1'b0;
        fin_any = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_bram_fin === 1'b1) fin_any = 1;
        end
        check("abort accepted", 64'(acc), 2);
        check("abort fin", 64'(fin_any), 0);
        check("abort ready", 64'(bus.o_axis_ready), 0);
        check("abort count", 64'(bus.o_bram_count), 0);
        check("abort writes", 64'(wr_addr_q.size()), 2);
        if (wr_addr_q.size() == 2) begin
            check("abort addr0", 64'(wr_addr_q[0]), 0);
            check("abort addr1", 64'(wr_addr_q[1]), 1);
        end
        do_buffer(8, 100, "regrant");

        // Largest buffer: the fill compare must not wrap
        push_packet(300, UW'(1));
        do_buffer(255, 100, "max_a");
        do_buffer(255, 80, "max_b");

        // Random packets, sizes and valid gaps
        for (int it = 0; it < 10; it++) begin
            if (src_q.size() == 0) push_packet($urandom_range(1, 12), UW'($urandom));
            do_buffer($urandom_range(1, 10), $urandom_range(40, 100), $sformatf("rnd%0d", it));
        end

        // Asynchronous reset in the middle of WRITE
        src_q.delete();
        push_packet(10, UW'(1));
        bus.i_bram_en   = 1'b1;
        bus.i_bram_size = AW'(8);
        acc = 0;
        for (int c = 0; c < 20 && acc < 3; c++) begin
            step_stream(100, accepted);
            if (accepted) acc++;
        end
        check("pre_rst count", 64'(bus.o_bram_count), 3);
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        bus.i_axis_valid = 1'b0;
        bus.i_bram_en    = 1'b0;
        rst = 1'b1;
        src_q.delete();
        @(negedge clk);
        push_packet(2, UW'(1));
        do_buffer(8, 100, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
